alu_seq: RTL and testbench

Parametrised multi-cycle ALU for the datapath. Single-cycle ops (add/sub/logic/shift/rotate/neg/not/branch-target) finish in one clock; MUL and DIV are iterative (one bit per clock), so the combinational multiplier and divider arrays are gone. A start/busy/done handshake lets the control unit stall on long ops. The 2·WIDTH result feeds the Z (HI/LO) register pair.

---
 rtl/alu_if.sv | 25 ++
 rtl/alu_seq.sv | 213 +++++++++++++++++++++
 tb/tb_alu_seq.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_if.sv
// Request/result bundle between the control unit and alu_seq.
// The master drives operands and start; the slave returns rc/busy/done/dbz.
interface alu_if #(
  parameter int WIDTH = 32
) ();
  logic               start;
  logic [4:0]         opcode;
  logic [WIDTH-1:0]   ra;
  logic [WIDTH-1:0]   rb;
  logic               brn_flag;
  logic [2*WIDTH-1:0] rc;
  logic               busy;
  logic               done;
  logic               dbz;

  modport master (
    output start, opcode, ra, rb, brn_flag,
    input  rc, busy, done, dbz
  );

  modport slave (
    input  start, opcode, ra, rb, brn_flag,
    output rc, busy, done, dbz
  );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle ALU: one-clock logic ops, bit-serial MUL/DIV, start/busy/done.
// Define ALU_SIGNED_MULDIV_EN for two's-complement MUL/DIV.
module alu_seq #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input logic clk,
  input logic clear,
  alu_if.slave bus
);

  localparam logic [4:0] OP_LDW  = 5'b00000;
  localparam logic [4:0] OP_LDWI = 5'b00001;
  localparam logic [4:0] OP_STW  = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_BRN  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV
  } state_t;

  state_t state, state_nx;

  logic [SHW-1:0]     cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0]   opb;
  logic [2*WIDTH-1:0] fin;
  logic [2*WIDTH-1:0] rc_q;
  logic               done_q;
  logic               dbz_q;

  logic               accept;
  logic               is_mul;
  logic               is_div;
  logic               dz;
  logic               single;
  logic               last;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shl;
  logic [WIDTH:0]     diff;

  logic [SHW-1:0]     sh;
  logic [SHW-1:0]     shn;
  logic [WIDTH-1:0]   alu_lo;
  logic [WIDTH-1:0]   alu_hi;
  logic               alu_keep;

  assign bus.rc   = rc_q;
  assign bus.done = done_q;
  assign bus.dbz  = dbz_q;
  assign bus.busy = (state != IDLE);

  assign accept = bus.start && (state == IDLE);
  assign is_mul = (bus.opcode == OP_MUL);
  assign is_div = (bus.opcode == OP_DIV);
  assign dz     = is_div && (bus.rb == '0);
  assign single = !is_mul && !(is_div && !dz);
  assign last   = (cnt == LAST);

`ifdef ALU_SIGNED_MULDIV_EN
  logic sa;
  logic sb;

  assign mag_a = bus.ra[WIDTH-1] ? -bus.ra : bus.ra;
  assign mag_b = bus.rb[WIDTH-1] ? -bus.rb : bus.rb;

  // Magnitudes were iterated; restore signs on the final edge.
  always_comb begin
    fin = acc_nx;
    if (state == MUL) begin
      if (sa ^ sb) fin = -acc_nx;
    end else begin
      if (sa)      fin[2*WIDTH-1:WIDTH] = -acc_nx[2*WIDTH-1:WIDTH];
      if (sa ^ sb) fin[WIDTH-1:0]       = -acc_nx[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      sa <= 1'b0;
      sb <= 1'b0;
    end else if (accept) begin
      sa <= bus.ra[WIDTH-1];
      sb <= bus.rb[WIDTH-1];
    end
  end
`else
  assign mag_a = bus.ra;
  assign mag_b = bus.rb;
  assign fin   = acc_nx;
`endif

  // acc holds {partial, multiplier} for MUL and {remainder, dividend} for DIV.
  always_comb begin
    acc_nx = acc;
    sum    = {1'b0, acc[2*WIDTH-1:WIDTH]}
           + {1'b0, (acc[0] ? opb : {WIDTH{1'b0}})};
    shl    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff   = shl - {1'b0, opb};
    unique case (state)
      MUL: acc_nx = {sum, acc[WIDTH-1:1]};
      DIV: begin
        if (diff[WIDTH])
          acc_nx = {shl[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        else
          acc_nx = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end
      default: acc_nx = acc;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept && is_mul)
          state_nx = MUL;
        else if (accept && is_div && !dz)
          state_nx = DIV;
      end
      MUL, DIV: begin
        if (last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign sh  = bus.rb[SHW-1:0];
  assign shn = SHW'(0) - sh;

  always_comb begin
    alu_lo   = '0;
    alu_hi   = '0;
    alu_keep = 1'b0;
    unique case (bus.opcode)
      OP_LDW, OP_LDWI, OP_STW,
      OP_ADD, OP_ADDI: alu_lo = bus.ra + bus.rb;
      OP_SUB:          alu_lo = bus.ra - bus.rb;
      OP_SHR:          alu_lo = bus.ra >> sh;
      OP_SHL:          alu_lo = bus.ra << sh;
      OP_ROR:          alu_lo = WIDTH'({bus.ra, bus.ra} >> sh);
      OP_ROL:          alu_lo = WIDTH'({bus.ra, bus.ra} >> shn);
      OP_AND, OP_ANDI: alu_lo = bus.ra & bus.rb;
      OP_OR, OP_ORI:   alu_lo = bus.ra | bus.rb;
      OP_NEG:          alu_lo = -bus.rb;
      OP_NOT:          alu_lo = ~bus.rb;
      OP_BRN:          alu_lo = bus.brn_flag ? bus.ra + bus.rb : bus.ra;
      OP_DIV: begin
        alu_hi = bus.ra;
        alu_lo = '1;
      end
      OP_NOP, OP_HALT: alu_keep = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      opb    <= '0;
      rc_q   <= '0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= 1'b0;
      if (state != IDLE) begin
        acc <= acc_nx;
        cnt <= last ? '0 : cnt + SHW'(1);
        if (last) begin
          rc_q   <= fin;
          done_q <= 1'b1;
        end
      end else if (accept) begin
        dbz_q <= dz;
        cnt   <= '0;
        acc   <= {{WIDTH{1'b0}}, mag_a};
        opb   <= mag_b;
        if (single) begin
          done_q <= 1'b1;
          if (!alu_keep) rc_q <= {alu_hi, alu_lo};
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: vector table through a scoreboard queue,
// plus ignored-start, back-to-back and mid-operation reset sequences.
module tb_alu_seq;

  localparam int W = 32;

  localparam logic [4:0] OP_LDWI = 5'b00001;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_BRN  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_BAD  = 5'b11111;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        brn;
    logic [63:0] rc;
    logic        dbz;
    int          lat;
  } vec_t;

  typedef struct {
    logic [63:0] rc;
    logic        dbz;
  } exp_t;

  logic clk;
  logic clear;
  int   checks;
  int   failures;
  int   spurious;
  exp_t sb_q[$];
  vec_t tv[$];

  alu_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (clear && bus.done) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        spurious++;
        $display("FAIL spurious_done: got done=1 expected no done");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("rc", bus.rc, e.rc);
        chk("dbz", {63'd0, bus.dbz}, {63'd0, e.dbz});
      end
    end
  end

  function automatic vec_t mk(logic [4:0] op, logic [31:0] a,
                              logic [31:0] b, logic brn,
                              logic [63:0] rc, logic dbz, int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.brn = brn;
    v.rc = rc; v.dbz = dbz; v.lat = lat;
    return v;
  endfunction

  function automatic logic [63:0] model(logic [4:0] op,
                                        logic [31:0] a, logic [31:0] b);
`ifdef ALU_SIGNED_MULDIV_EN
    longint sa;
    longint sbv;
    longint q;
    longint r;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    if (op == OP_MUL) return 64'(sa * sbv);
    q = sa / sbv;
    r = sa % sbv;
    return {r[31:0], q[31:0]};
`else
    logic [63:0] ua;
    logic [63:0] ub;
    logic [63:0] q;
    logic [63:0] r;
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (op == OP_MUL) return ua * ub;
    q = ua / ub;
    r = ua % ub;
    return {r[31:0], q[31:0]};
`endif
  endfunction

  // Caller sits at a negedge; returns at the negedge where done is seen.
  task automatic run_op(input vec_t v);
    int   lat;
    logic bsy;
    exp_t e;
    bus.opcode   = v.op;
    bus.ra       = v.a;
    bus.rb       = v.b;
    bus.brn_flag = v.brn;
    bus.start    = 1'b1;
    e.rc  = v.rc;
    e.dbz = v.dbz;
    sb_q.push_back(e);
    @(posedge clk);
    lat = 0;
    bsy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      lat++;
      if (bus.busy) bsy = 1'b1;
      if (bus.done) break;
    end
    chk("latency", 64'(lat), 64'(v.lat));
    chk("busy_seen", {63'd0, bsy}, {63'd0, (v.lat > 1)});
  endtask

  initial begin
    int   lat;
    vec_t v;
    exp_t e;
    logic [63:0] mul2;

    checks   = 0;
    failures = 0;
    spurious = 0;
    clear        = 1'b0;
    bus.start    = 1'b0;
    bus.opcode   = OP_NOP;
    bus.ra       = '0;
    bus.rb       = '0;
    bus.brn_flag = 1'b0;

`ifdef ALU_SIGNED_MULDIV_EN
    mul2 = 64'hFFFFFFFF_FFFFFFFE;
`else
    mul2 = 64'h00000001_FFFFFFFE;
`endif
    tv.push_back(mk(OP_ADD, 32'h7FFFFFFF, 32'h1, 0, 64'h80000000, 0, 1));
    tv.push_back(mk(OP_MUL, 32'hFFFFFFFF, 32'h2, 0, mul2, 0, 33));
    tv.push_back(mk(OP_DIV, 32'd100, 32'd7, 0, {32'd2, 32'd14}, 0, 33));
    tv.push_back(mk(OP_DIV, 32'd100, 32'd0, 0,
                    {32'd100, 32'hFFFFFFFF}, 1, 1));
    tv.push_back(mk(OP_ROL, 32'h80000001, 32'h1, 0, 64'h3, 0, 1));
    tv.push_back(mk(OP_ROR, 32'h80000001, 32'h1, 0, 64'hC0000000, 0, 1));
    tv.push_back(mk(OP_BRN, 32'h40, 32'h10, 0, 64'h40, 0, 1));
    tv.push_back(mk(OP_BRN, 32'h40, 32'h10, 1, 64'h50, 0, 1));
    tv.push_back(mk(OP_SUB, 32'd5, 32'd7, 0, 64'hFFFFFFFE, 0, 1));
    tv.push_back(mk(OP_SHR, 32'hF0000000, 32'h24, 0, 64'h0F000000, 0, 1));
    tv.push_back(mk(OP_SHL, 32'h1, 32'd31, 0, 64'h80000000, 0, 1));
    tv.push_back(mk(OP_ROL, 32'h12345678, 32'h0, 0, 64'h12345678, 0, 1));
    tv.push_back(mk(OP_NEG, 32'h0, 32'h1, 0, 64'hFFFFFFFF, 0, 1));
    tv.push_back(mk(OP_NOT, 32'h0, 32'h0, 0, 64'hFFFFFFFF, 0, 1));
    tv.push_back(mk(OP_AND, 32'hF0F0, 32'hFF00, 0, 64'hF000, 0, 1));
    tv.push_back(mk(OP_ORI, 32'hF0F0, 32'hFF00, 0, 64'hFFF0, 0, 1));
    tv.push_back(mk(OP_NOP, 32'h1, 32'h1, 0, 64'hFFF0, 0, 1));
    tv.push_back(mk(OP_BAD, 32'h1, 32'h1, 0, 64'h0, 0, 1));
    tv.push_back(mk(OP_LDWI, 32'd10, 32'd20, 0, 64'd30, 0, 1));
    for (int i = 0; i < 6; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  op;
      a  = $urandom;
      b  = (i < 2) ? $urandom_range(1, 1000) : $urandom;
      if (b == 0) b = 32'd3;
      op = i[0] ? OP_DIV : OP_MUL;
      tv.push_back(mk(op, a, b, 0, model(op, a, b), 0, 33));
    end

    repeat (2) @(negedge clk);
    chk("rst_rc", bus.rc, 64'd0);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_done", {63'd0, bus.done}, 64'd0);
    chk("rst_dbz", {63'd0, bus.dbz}, 64'd0);
    clear = 1'b1;
    @(negedge clk);

    foreach (tv[i]) run_op(tv[i]);

    @(negedge clk);
    chk("done_drops", {63'd0, bus.done}, 64'd0);

    // MUL with a stray start mid-flight, then a start in the done cycle.
    bus.opcode = OP_MUL;
    bus.ra     = 32'd3;
    bus.rb     = 32'd5;
    bus.start  = 1'b1;
    e.rc  = 64'd15;
    e.dbz = 1'b0;
    sb_q.push_back(e);
    @(posedge clk);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      bus.start = (lat == 5);
      if (lat == 5) begin
        bus.opcode = OP_ADD;
        bus.ra     = 32'd1;
        bus.rb     = 32'd1;
      end
      if (lat == 6) begin
        bus.ra = 32'hDEAD;
        bus.rb = 32'hBEEF;
      end
      if (bus.done) break;
    end
    chk("mul_ignore_lat", 64'(lat), 64'd33);
    v = mk(OP_ADD, 32'd2, 32'd3, 0, 64'd5, 0, 1);
    run_op(v);

    // Abort a DIV with an asynchronous reset.
    bus.opcode = OP_DIV;
    bus.ra     = 32'd1000;
    bus.rb     = 32'd3;
    bus.start  = 1'b1;
    @(posedge clk);
    repeat (10) @(negedge clk);
    bus.start = 1'b0;
    clear = 1'b0;
    #1;
    chk("abort_rc", bus.rc, 64'd0);
    chk("abort_busy", {63'd0, bus.busy}, 64'd0);
    chk("abort_dbz", {63'd0, bus.dbz}, 64'd0);
    @(negedge clk);
    clear = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_no_done", 64'(spurious), 64'd0);
    chk("queue_empty", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
